// File: rtl/cic_pkg.sv
// Shared helpers for the CIC output path: channel-tag sizing.
package cic_pkg;

  localparam int unsigned DefaultWordLengthBits = 36;
  localparam int unsigned DefaultFifoDepth      = 4;

  // Width of a channel index; never zero so a tag port always exists.
  function automatic int unsigned channel_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Per-channel word FIFO with registered occupancy; ready depends only on the count.
module stream_fifo #(
  parameter int unsigned WordLengthBits = 36,
  parameter int unsigned Depth          = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [WordLengthBits-1:0] in_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  output logic [WordLengthBits-1:0] out_o,
  output logic                      out_valid_o,
  input  logic                      pop_i
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth) + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(Depth);

  logic [WordLengthBits-1:0] mem_q [Depth];
  logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]           count_q, count_d;
  logic                      push;
  logic                      pop;

  // A full FIFO refuses a write even when it is popped in the same cycle.
  assign in_ready_o  = (count_q != FullCount);
  assign out_valid_o = (count_q != '0);
  assign out_o       = mem_q[rd_ptr_q];
  assign push        = in_valid_i && in_ready_o;
  assign pop         = pop_i && out_valid_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem_q[wr_ptr_q] <= in_i;
    end
  end

endmodule

// File: rtl/cic_output_arbiter.sv
// Merges NumChannels CIC output streams into one tagged stream via per-channel
// FIFOs and a round-robin scheduler; dropped words raise a sticky overflow flag.
module cic_output_arbiter
  import cic_pkg::*;
#(
  parameter int unsigned NumChannels    = 2,
  parameter int unsigned WordLengthBits = DefaultWordLengthBits,
  parameter int unsigned FifoDepth      = DefaultFifoDepth,
  parameter int unsigned ChannelBits    = channel_bits(NumChannels)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NumChannels-1:0][WordLengthBits-1:0] in_i,
  input  logic [NumChannels-1:0]                   in_valid_i,
  output logic [NumChannels-1:0]                   in_ready_o,
  output logic [WordLengthBits-1:0]                out_o,
  output logic [ChannelBits-1:0]                   out_channel_o,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic [NumChannels-1:0]                   overflow_o
);

  localparam logic [ChannelBits-1:0] LastGrantRst = ChannelBits'(NumChannels - 1);

  logic [WordLengthBits-1:0] fifo_head [NumChannels];
  logic [NumChannels-1:0]    fifo_valid;
  logic [NumChannels-1:0]    fifo_ready;
  logic [NumChannels-1:0]    fifo_pop;

  logic [WordLengthBits-1:0] out_q, out_d;
  logic [ChannelBits-1:0]    out_channel_q, out_channel_d;
  logic                      out_valid_q, out_valid_d;
  logic [ChannelBits-1:0]    last_grant_q, last_grant_d;
  logic [NumChannels-1:0]    overflow_q, overflow_d;

  logic                      load;
  logic                      do_pop;
  logic                      grant_found;
  logic [ChannelBits-1:0]    grant_idx;

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    stream_fifo #(
      .WordLengthBits(WordLengthBits),
      .Depth         (FifoDepth)
    ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .in_i       (in_i[c]),
      .in_valid_i (in_valid_i[c]),
      .in_ready_o (fifo_ready[c]),
      .out_o      (fifo_head[c]),
      .out_valid_o(fifo_valid[c]),
      .pop_i      (fifo_pop[c])
    );
  end

  assign in_ready_o    = fifo_ready;
  assign out_o         = out_q;
  assign out_channel_o = out_channel_q;
  assign out_valid_o   = out_valid_q;
  assign overflow_o    = overflow_q;

  assign load   = !out_valid_q || out_ready_i;
  assign do_pop = load && grant_found;

  // Search starts just after the last served channel, so it ends up lowest priority.
  always_comb begin
    int unsigned cand;
    grant_found = 1'b0;
    grant_idx   = last_grant_q;
    cand        = 0;
    for (int unsigned i = 1; i <= NumChannels; i++) begin
      cand = (32'(last_grant_q) + i) % NumChannels;
      if (!grant_found && fifo_valid[ChannelBits'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ChannelBits'(cand);
      end
    end
  end

  always_comb begin
    fifo_pop = '0;
    for (int unsigned c = 0; c < NumChannels; c++) begin
      fifo_pop[c] = do_pop && (grant_idx == ChannelBits'(c));
    end
  end

  always_comb begin
    out_d         = out_q;
    out_channel_d = out_channel_q;
    out_valid_d   = out_valid_q;
    last_grant_d  = last_grant_q;
    overflow_d    = overflow_q | (in_valid_i & ~fifo_ready);
    if (load) begin
      out_valid_d = grant_found;
      if (grant_found) begin
        out_d         = fifo_head[grant_idx];
        out_channel_d = grant_idx;
        last_grant_d  = grant_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q         <= '0;
      out_channel_q <= '0;
      out_valid_q   <= 1'b0;
      last_grant_q  <= LastGrantRst;
      overflow_q    <= '0;
    end else begin
      out_q         <= out_d;
      out_channel_q <= out_channel_d;
      out_valid_q   <= out_valid_d;
      last_grant_q  <= last_grant_d;
      overflow_q    <= overflow_d;
    end
  end

endmodule
